branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, meaning the number of table entries (power of two, at least 4).
REQ-002 SHALL have parameter XLEN, default 32, meaning the PC/target width.
REQ-003 SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, width 1, synchronous clear of all table state.
REQ-006 SHALL have port pc_f, input, width XLEN, fetch-stage PC to predict.
REQ-007 SHALL have port pred_taken, output, width 1, prediction for pc_f.
REQ-008 SHALL have port pred_target, output, width XLEN, predicted target for pc_f; 0 when pred_taken=0.
REQ-009 SHALL have port upd_valid, input, width 1, a resolved conditional branch is presented this cycle.
REQ-010 SHALL have port upd_pc, input, width XLEN, PC of the resolved branch.
REQ-011 SHALL have port upd_taken, input, width 1, resolved outcome from the branch comparator.
REQ-012 SHALL have port upd_target, input, width XLEN, resolved target address.
REQ-013 SHALL have port upd_pred_taken, input, width 1, prediction originally issued for that branch.
REQ-014 SHALL have port mispredict, output, width 1, registered one-cycle pulse flagging the previous cycle's update as a misprediction.

Function
REQ-015 SHALL use index = pc[IDXW+1:2] with IDXW = log2(ENTRIES), and tag = pc[XLEN-1:IDXW+2].
REQ-016 SHALL hold a 2-bit saturating counter per entry with encoding 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
REQ-017 SHALL hold per-entry BTB fields: valid, tag, target.
REQ-018 SHALL compute the prediction combinationally from pc_f with zero-cycle latency: pred_taken = counter[1] AND valid AND tag match.
REQ-019 SHALL, on upd_valid with upd_taken=1, increment the indexed counter (saturating at 11) and write valid=1, the tag of upd_pc and upd_target.
REQ-020 SHALL, on upd_valid with upd_taken=0, decrement the indexed counter (saturating at 00) and leave the BTB fields unchanged.
REQ-021 SHALL keep tables and counters unchanged when upd_valid=0.
REQ-022 SHALL, when pc_f and upd_pc share an index in the same cycle, base the prediction on the pre-update state (read-before-write, no bypass).
REQ-023 SHALL, on a taken update that misses the tag, overwrite the entry and leave the counter at 10 (weak-taken), not inc/dec the old value.
REQ-024 SHALL give flush priority over a simultaneous update: all counters become 01, all valid bits 0, and the update is dropped.
REQ-025 SHALL set mispredict, on the cycle after upd_valid, to (upd_taken XOR upd_pred_taken), and 0 otherwise; flush does not suppress it.

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk, set all counters to 01, all valid bits to 0 and mispredict to 0; targets and tags need no reset.
REQ-027 SHALL produce pred_taken=0 and pred_target=0 for any pc_f immediately after reset.
REQ-028 SHALL, when reset asserts mid-operation, discard any in-flight update and any pending mispredict pulse.

Structure
REQ-029 SHALL place the 2-bit counter state enum (SNT/WNT/WT/ST) and its reset value constant in the shared def.sv package, alongside the existing branch funct3 constants.
REQ-030 SHALL implement the counter saturating next-state logic as one sub-module, sat_counter2 (inputs: current state, taken; output: next state); all else stays flat.

Verification
REQ-031 SHALL cover reset then pc_f=0x100 -> pred_taken=0, pred_target=0.
REQ-032 SHALL cover a taken update pc=0x100, target=0x200, followed by pc_f=0x100 in the next cycle -> pred_taken=1, pred_target=0x200.
REQ-033 SHALL cover three not-taken updates at 0x100 after REQ-032 -> counter reaches 00 and pred_taken=0; a fourth leaves it at 00.
REQ-034 SHALL cover aliasing with ENTRIES=64 after REQ-032: pc_f=0x200 (same index, different tag) -> pred_taken=0.
REQ-035 SHALL cover a same-cycle taken update and pc_f=0x100 on a fresh entry -> pred_taken=0 that cycle and 1 the next cycle.
REQ-036 SHALL cover upd_taken=1 with upd_pred_taken=0 -> mispredict=1 for exactly one cycle; a flush asserted with an update -> all predictions 0 afterwards.

Source files
------------

// File: rtl/def.sv
// Shared definitions: branch funct3 encodings and the 2-bit predictor counter type.
package def;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    localparam cnt_t CNT_RESET = WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating branch counter.
module sat_counter2
    import def::*;
(
    input  cnt_t cur,
    input  logic taken,
    output cnt_t nxt
);

    always_comb begin
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with BTB; combinational lookup, one update per cycle.
module branch_predictor
    import def::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    output logic            mispredict
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    cnt_t               cnt      [ENTRIES];
    logic [ENTRIES-1:0] valid;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDXW-1:0] f_idx, u_idx;
    logic [TAGW-1:0] f_tag, u_tag;
    logic            f_hit, u_hit;
    logic [1:0]      f_cnt;
    cnt_t            sat_nxt, cnt_wr;
    logic            unused_pc_lsb;

    assign f_idx = pc_f[IDXW+1:2];
    assign f_tag = pc_f[XLEN-1:IDXW+2];
    assign u_idx = upd_pc[IDXW+1:2];
    assign u_tag = upd_pc[XLEN-1:IDXW+2];
    assign unused_pc_lsb = ^{pc_f[1:0], upd_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not visible until next cycle.
    assign f_hit       = valid[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_cnt       = cnt[f_idx];
    assign pred_taken  = f_hit && f_cnt[1];
    assign pred_target = pred_taken ? target_q[f_idx] : '0;

    assign u_hit = valid[u_idx] && (tag_q[u_idx] == u_tag);

    sat_counter2 u_sat (
        .cur   (cnt[u_idx]),
        .taken (upd_taken),
        .nxt   (sat_nxt)
    );

    // A taken branch that displaces another entry starts fresh at weak-taken.
    assign cnt_wr = (upd_taken && !u_hit) ? WT : sat_nxt;

    // upd_valid qualifies upd_* for exactly one cycle; there is no back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_RESET;
            valid <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_RESET;
            valid <= '0;
        end else if (upd_valid) begin
            cnt[u_idx] <= cnt_wr;
            if (upd_taken) valid[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && upd_valid && upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mispredict <= 1'b0;
        else        mispredict <= upd_valid && (upd_taken ^ upd_pred_taken);
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor plus flush and async-reset sequences.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic        mispredict;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] pcf;
        logic        et;
        logic [31:0] etgt;
        logic        emis;
    } vec_t;

    vec_t vecs[$];

    branch_predictor #(.ENTRIES(64), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .pc_f           (pc_f),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic upt, input logic [31:0] pcf,
                       input logic et, input logic [31:0] etgt, input logic emis);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
        v.pcf = pcf; v.et = et; v.etgt = etgt; v.emis = emis;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; prediction checked before the rising edge, mispredict after it.
    task automatic step(input int n, input vec_t v);
        upd_valid      = v.uv;
        upd_pc         = v.upc;
        upd_taken      = v.ut;
        upd_target     = v.utgt;
        upd_pred_taken = v.upt;
        pc_f           = v.pcf;
        #1;
        check($sformatf("v%0d_pred_taken", n), {31'b0, pred_taken}, {31'b0, v.et});
        check($sformatf("v%0d_pred_target", n), pred_target, v.etgt);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_mispredict", n), {31'b0, mispredict}, {31'b0, v.emis});
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; pc_f = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;

        //    uv upc     ut utgt    upt pcf     et etgt    emis
        add(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h000, 0);
        add(1, 32'h100, 1, 32'h200, 1, 32'h300, 0, 32'h000, 0);
        add(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 32'h200, 0);
        add(0, 32'h000, 0, 32'h000, 0, 32'h200, 0, 32'h000, 0);
        add(1, 32'h100, 0, 32'h000, 1, 32'h100, 1, 32'h200, 1);
        add(1, 32'h100, 0, 32'h000, 0, 32'h100, 0, 32'h000, 0);
        add(1, 32'h100, 0, 32'h000, 0, 32'h100, 0, 32'h000, 0);
        add(1, 32'h100, 0, 32'h000, 0, 32'h100, 0, 32'h000, 0);
        add(1, 32'h100, 1, 32'h200, 0, 32'h100, 0, 32'h000, 1);
        add(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h000, 0);
        add(1, 32'h100, 1, 32'h240, 1, 32'h100, 0, 32'h000, 0);
        add(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 32'h240, 0);
        add(1, 32'h100, 1, 32'h240, 1, 32'h104, 0, 32'h000, 0);
        add(1, 32'h100, 1, 32'h240, 1, 32'h100, 1, 32'h240, 0);
        add(1, 32'h100, 0, 32'h000, 1, 32'h100, 1, 32'h240, 1);
        add(0, 32'h000, 0, 32'h000, 0, 32'h100, 1, 32'h240, 0);
        add(1, 32'h200, 0, 32'h999, 1, 32'h100, 1, 32'h240, 1);
        add(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h000, 0);
        add(1, 32'h100, 0, 32'h000, 0, 32'h100, 0, 32'h000, 0);
        add(1, 32'h200, 1, 32'h300, 0, 32'h200, 0, 32'h000, 1);
        add(0, 32'h000, 0, 32'h000, 0, 32'h200, 1, 32'h300, 0);
        add(0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 32'h000, 0);
        add(0, 32'h104, 1, 32'h500, 0, 32'h200, 1, 32'h300, 0);
        add(0, 32'h000, 0, 32'h000, 0, 32'h104, 0, 32'h000, 0);
        add(1, 32'h108, 1, 32'h600, 0, 32'h108, 0, 32'h000, 1);
        add(0, 32'h000, 0, 32'h000, 0, 32'h108, 1, 32'h600, 0);

        repeat (2) @(negedge clk);
        check("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        check("rst_pred_target", pred_target, 32'h0);
        check("rst_mispredict", {31'b0, mispredict}, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) step(i, vecs[i]);

        // Flush wins over a simultaneous update but the mispredict pulse still fires.
        flush = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h10C; upd_taken = 1'b1; upd_target = 32'h700; upd_pred_taken = 1'b0;
        pc_f = 32'h108;
        #1;
        check("flush_pre_pred", {31'b0, pred_taken}, 32'h1);
        @(posedge clk);
        #1;
        check("flush_mispredict", {31'b0, mispredict}, 32'h1);
        @(negedge clk);
        flush = 1'b0; upd_valid = 1'b0;
        pc_f = 32'h200; #1;
        check("flush_pred_200", {31'b0, pred_taken}, 32'h0);
        check("flush_tgt_200", pred_target, 32'h0);
        pc_f = 32'h108; #1;
        check("flush_pred_108", {31'b0, pred_taken}, 32'h0);
        pc_f = 32'h10C; #1;
        check("flush_pred_10c", {31'b0, pred_taken}, 32'h0);
        check("flush_tgt_10c", pred_target, 32'h0);
        @(posedge clk);
        #1;
        check("flush_mis_clear", {31'b0, mispredict}, 32'h0);
        @(negedge clk);

        // Asynchronous reset in the middle of an update and a pending mispredict pulse.
        upd_valid = 1'b1; upd_pc = 32'h110; upd_taken = 1'b1; upd_target = 32'h800; upd_pred_taken = 1'b0;
        pc_f = 32'h110;
        @(posedge clk);
        #1;
        check("arst_pre_mis", {31'b0, mispredict}, 32'h1);
        check("arst_pre_pred", {31'b0, pred_taken}, 32'h1);
        check("arst_pre_tgt", pred_target, 32'h800);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_mis", {31'b0, mispredict}, 32'h0);
        check("arst_pred", {31'b0, pred_taken}, 32'h0);
        check("arst_tgt", pred_target, 32'h0);
        @(posedge clk);
        #1;
        check("arst_hold_mis", {31'b0, mispredict}, 32'h0);
        check("arst_hold_pred", {31'b0, pred_taken}, 32'h0);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_post_mis", {31'b0, mispredict}, 32'h0);
        check("arst_post_pred", {31'b0, pred_taken}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
